stack_prog_loader: RTL and testbench

//  Upstream instruction source for stackCPU: accepts a program over a valid/ready stream,

---
 rtl/stack_prog_loader.sv | 165 ++++++++++++++++
 tb/tb_stack_prog_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_prog_loader.sv
// Program loader and instruction server for stackCPU: streams a program into memory, then runs it.
// Optional build macro STACK_PROG_LOADER_CHECKSUM_EN enables the XOR checksum of loaded words.
module stack_prog_loader #(
  parameter int                     INSTR_WIDTH = 16,
  parameter int                     PC_WIDTH    = 8,
  parameter int                     MEM_DEPTH   = 256,
  parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = 16'hF800
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [INSTR_WIDTH-1:0] ld_data,
  input  logic                   ld_last,
  input  logic                   start,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   cpu_reset,
  output logic                   end_of_prog,
  output logic [PC_WIDTH:0]      prog_len,
  output logic                   ovf,
  output logic [INSTR_WIDTH-1:0] checksum
);

  localparam int                AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int                PTR_W     = PC_WIDTH + 1;
  localparam logic [PTR_W-1:0]  DEPTH_PTR = PTR_W'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOADED,
    S_RELEASE,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t                 state, state_nxt;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       wr_ptr_nxt;
  logic [AW-1:0]          wr_addr;
  logic [1:0]             rel_cnt;
  logic                   xfer;
  logic                   new_prog;
  logic                   ovf_hit;
  logic                   wr_en;
  logic                   past_end;
  logic [INSTR_WIDTH-1:0] mem [MEM_DEPTH];

  // A handshake in IDLE/DONE begins a fresh program at slot 0.
  assign xfer       = ld_valid && ld_ready;
  assign new_prog   = xfer && ((state == S_IDLE) || (state == S_DONE));
  assign ovf_hit    = xfer && (state == S_LOAD) && (wr_ptr == DEPTH_PTR);
  assign wr_en      = xfer && !ovf_hit;
  assign wr_addr    = new_prog ? '0 : wr_ptr[AW-1:0];
  assign wr_ptr_nxt = new_prog ? PTR_W'(1) : wr_ptr + PTR_W'(1);
  assign past_end   = ({1'b0, pc} >= prog_len);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (xfer) begin
          state_nxt = ld_last ? S_LOADED : S_LOAD;
        end else if (start && (state == S_DONE)) begin
          state_nxt = S_RELEASE;
        end
      end
      S_LOAD: begin
        if (ovf_hit) begin
          state_nxt = S_ERR;
        end else if (xfer && ld_last) begin
          state_nxt = S_LOADED;
        end
      end
      S_LOADED: begin
        if (start) begin
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (rel_cnt == 2'd2) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (past_end) begin
          state_nxt = S_DONE;
        end
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ld_ready    = (state == S_IDLE) || (state == S_LOAD) || (state == S_DONE);
    cpu_reset   = (state != S_RUN);
    end_of_prog = 1'b0;
    instruction = HALT_INSTR;
    if (state == S_RUN) begin
      end_of_prog = past_end;
      if (!past_end) begin
        instruction = mem[pc[AW-1:0]];
      end
    end
  end

  // Three RELEASE cycles: start at edge N leaves cpu_reset asserted until edge N+3.
  always_ff @(posedge clk) begin
    if (!reset || (state != S_RELEASE)) begin
      rel_cnt <= 2'd0;
    end else begin
      rel_cnt <= rel_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      prog_len <= '0;
      ovf      <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr   <= wr_ptr_nxt;
        prog_len <= wr_ptr_nxt;
      end
      if (ovf_hit) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= ld_data;
    end
  end

`ifdef STACK_PROG_LOADER_CHECKSUM_EN
  logic [INSTR_WIDTH-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      checksum_q <= '0;
    end else if (wr_en) begin
      checksum_q <= new_prog ? ld_data : (checksum_q ^ ld_data);
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_stack_prog_loader.sv
// Scoreboard bench for stack_prog_loader (MEM_DEPTH=4): random programs checked against a queue model.
module tb_stack_prog_loader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [15:0] ld_data = 16'h0;
  logic        ld_last = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  pc = 8'h0;
  logic [15:0] instruction;
  logic        cpu_reset;
  logic        end_of_prog;
  logic [8:0]  prog_len;
  logic        ovf;
  logic [15:0] checksum;

  stack_prog_loader #(
    .INSTR_WIDTH(16),
    .PC_WIDTH   (8),
    .MEM_DEPTH  (DEPTH),
    .HALT_INSTR (16'hF800)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .start      (start),
    .pc         (pc),
    .instruction(instruction),
    .cpu_reset  (cpu_reset),
    .end_of_prog(end_of_prog),
    .prog_len   (prog_len),
    .ovf        (ovf),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sig;
    logic [31:0] val;
    string       name;
  } chk_t;

  chk_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] m_prog[$];
  logic [15:0] m_csum = 16'h0;
  bit          m_ovf = 1'b0;
  logic [15:0] wbuf[8];

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      0:       return {31'h0, ld_ready};
      1:       return {31'h0, cpu_reset};
      2:       return {23'h0, prog_len};
      3:       return {31'h0, ovf};
      4:       return {16'h0, instruction};
      5:       return {31'h0, end_of_prog};
      default: return {16'h0, checksum};
    endcase
  endfunction

  function automatic logic [15:0] csum_exp(input logic [15:0] v);
`ifdef STACK_PROG_LOADER_CHECKSUM_EN
    return v;
`else
    return 16'h0 & v;
`endif
  endfunction

  task automatic exp_chk(input int sig, input logic [31:0] v, input string nm);
    chk_t c;
    c.sig  = sig;
    c.val  = v;
    c.name = nm;
    sb.push_back(c);
  endtask

  // Monitor: everything queued during a cycle is compared at that cycle's falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t        c;
      logic [31:0] act;
      c   = sb.pop_front();
      act = actual(c.sig);
      n_vec++;
      if (act !== c.val) begin
        n_err++;
        $display("FAIL %s: got %0h expected %0h (t=%0t)", c.name, act, c.val, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    m_prog.delete();
    m_csum = 16'h0;
    m_ovf  = 1'b0;
    exp_chk(0, 32'd1, "rst_ld_ready");
    exp_chk(1, 32'd1, "rst_cpu_reset");
    exp_chk(2, 32'd0, "rst_prog_len");
    exp_chk(3, 32'd0, "rst_ovf");
    exp_chk(4, 32'hF800, "rst_instruction");
    exp_chk(5, 32'd0, "rst_end_of_prog");
    exp_chk(6, 32'd0, "rst_checksum");
  endtask

  task automatic load_prog(input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(0, 2) == 0) begin
        ld_data = 16'($urandom);
        tick();
      end
      ld_valid = 1'b1;
      ld_data  = wbuf[i];
      ld_last  = last && (i == n - 1);
      exp_chk(0, 32'd1, "ld_ready_during_load");
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      if (i == 0) begin
        m_prog.delete();
        m_csum = 16'h0;
      end
      if (m_prog.size() < DEPTH) begin
        m_prog.push_back(wbuf[i]);
        m_csum ^= wbuf[i];
      end else begin
        m_ovf = 1'b1;
      end
      exp_chk(2, 32'(m_prog.size()), "prog_len_load");
      exp_chk(3, {31'h0, m_ovf}, "ovf_load");
      exp_chk(0, (m_ovf || (last && i == n - 1)) ? 32'd0 : 32'd1, "ld_ready_after_word");
      exp_chk(1, 32'd1, "cpu_reset_load");
      if (!m_ovf) exp_chk(6, {16'h0, csum_exp(m_csum)}, "checksum_load");
    end
  endtask

  task automatic release_chk(input bit do_start);
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    pc = 8'h0;
    for (int k = 0; k < 3; k++) begin
      exp_chk(1, 32'd1, "cpu_reset_release");
      exp_chk(5, 32'd0, "eop_release");
      exp_chk(4, 32'hF800, "instr_release");
      tick();
    end
    exp_chk(1, 32'd0, "cpu_reset_run");
    exp_chk(2, 32'(m_prog.size()), "prog_len_run");
  endtask

  task automatic run_rand(input int npc);
    for (int j = 0; j < npc; j++) begin
      pc = 8'($urandom_range(0, m_prog.size() - 1));
      exp_chk(4, {16'h0, m_prog[pc]}, "instr_run");
      exp_chk(5, 32'd0, "eop_in_range");
      tick();
    end
    pc = 8'($urandom_range(m_prog.size(), 255));
    exp_chk(5, 32'd1, "eop_past_end");
    exp_chk(4, 32'hF800, "instr_past_end");
    tick();
    exp_chk(1, 32'd1, "cpu_reset_done");
    exp_chk(5, 32'd0, "eop_done");
    exp_chk(4, 32'hF800, "instr_done");
    exp_chk(0, 32'd1, "ld_ready_done");
    exp_chk(2, 32'(m_prog.size()), "prog_len_done");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    do_reset();

    // Directed three-word program.
    wbuf[0] = 16'h0005; wbuf[1] = 16'h0003; wbuf[2] = 16'h0800;
    load_prog(3, 1'b1);
    exp_chk(2, 32'd3, "prog_len_three");
    release_chk(1'b1);
    pc = 8'd1;
    exp_chk(4, 32'h0003, "instr_pc1");
    tick();
    pc = 8'd3;
    exp_chk(5, 32'd1, "eop_pc3");
    tick();
    exp_chk(1, 32'd1, "cpu_reset_after_eop");

    // Checksum of a new program loaded from DONE, then another new program.
    wbuf[0] = 16'h00FF; wbuf[1] = 16'h0F0F;
    load_prog(2, 1'b1);
    exp_chk(6, {16'h0, csum_exp(16'h0FF0)}, "checksum_0ff0");
    release_chk(1'b1);
    run_rand(1);
    wbuf[0] = 16'h1234;
    load_prog(1, 1'b1);
    exp_chk(6, {16'h0, csum_exp(16'h1234)}, "checksum_1234");

    // LOADED: start and ld_valid together, start wins.
    start    = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 16'($urandom);
    exp_chk(0, 32'd0, "ld_ready_loaded");
    tick();
    start    = 1'b0;
    ld_valid = 1'b0;
    exp_chk(2, 32'd1, "prog_len_start_wins");
    release_chk(1'b0);
    run_rand(2);

    // Random programs, with occasional rerun from DONE.
    for (int it = 0; it < 10; it++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      for (int w = 0; w < n; w++) wbuf[w] = 16'($urandom);
      load_prog(n, 1'b1);
      release_chk(1'b1);
      run_rand($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) begin
        release_chk(1'b1);
        run_rand(2);
      end
    end

    // Reset for one cycle in RUN, then a single-word reload.
    release_chk(1'b1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_prog.delete();
    m_csum = 16'h0;
    exp_chk(1, 32'd1, "cpu_reset_after_run_reset");
    exp_chk(2, 32'd0, "prog_len_after_run_reset");
    exp_chk(0, 32'd1, "ld_ready_after_run_reset");
    exp_chk(6, 32'd0, "checksum_after_run_reset");
    wbuf[0] = 16'($urandom);
    load_prog(1, 1'b1);
    exp_chk(2, 32'd1, "prog_len_single");
    exp_chk(0, 32'd0, "ld_ready_single_loaded");

    // Overflow: five words into a four-word memory.
    do_reset();
    for (int w = 0; w < 5; w++) wbuf[w] = 16'($urandom);
    load_prog(5, 1'b0);
    exp_chk(3, 32'd1, "ovf_set");
    exp_chk(2, 32'd4, "prog_len_ovf");
    start    = 1'b1;
    ld_valid = 1'b1;
    tick();
    start    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_chk(1, 32'd1, "cpu_reset_err");
      exp_chk(0, 32'd0, "ld_ready_err");
      exp_chk(3, 32'd1, "ovf_sticky");
      exp_chk(2, 32'd4, "prog_len_err");
      tick();
    end
    ld_valid = 1'b0;
    do_reset();
    tick();
    @(negedge clk);
    #1;
    n_vec++;
    if (ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL final_ld_ready: got %0h expected 1", ld_ready);
    end
    n_vec++;
    if (cpu_reset !== 1'b1) begin
      n_err++;
      $display("FAIL final_cpu_reset: got %0h expected 1", cpu_reset);
    end
    n_vec++;
    if (prog_len !== 9'd0) begin
      n_err++;
      $display("FAIL final_prog_len: got %0h expected 0", prog_len);
    end
    n_vec++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL final_ovf: got %0h expected 0", ovf);
    end
    n_vec++;
    if (instruction !== 16'hF800) begin
      n_err++;
      $display("FAIL final_instruction: got %0h expected f800", instruction);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
